// File: rtl/online_adder_serial.sv
// Digit-serial MSD-first online adder/subtractor for signed-digit operands.
// NCH independent lanes share one valid/ready handshake and frame markers.
// Online delay of 2: result position -1 appears once digit 1 is accepted.
//
// state  | meaning
// IDLE   | waiting for a digit flagged in_first
// FILL   | digit 0 held, next digit produces position -1
// STREAM | one result digit per accepted input digit
// FLUSH1 | input closed, emit position N-2 using carry-in 0
// FLUSH2 | emit final position N-1, mark out_last
module online_adder_serial #(
  parameter int NCH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_sub,
  input  logic [2*NCH-1:0] in_x,
  input  logic [2*NCH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last,
  output logic [2*NCH-1:0] out_z,
  output logic             restart_err
);

  typedef enum logic [2:0] {IDLE, FILL, STREAM, FLUSH1, FLUSH2} state_t;

  state_t           state;
  logic             sub_q;
  logic             single;
  logic [NCH-1:0]   s1_prev;
  logic [NCH-1:0]   yn_prev;
  logic [NCH-1:0]   pend_p;

  logic             acc;
  logic             out_free;
  logic             eff_sub;
  logic             cin;
  logic [NCH-1:0]   yp_e;
  logic [NCH-1:0]   yn_e;
  logic [NCH-1:0]   c_new;
  logic [NCH-1:0]   s1_new;
  logic [NCH-1:0]   cc;
  logic [NCH-1:0]   s2;
  logic [2*NCH-1:0] emit_z;
  logic [2*NCH-1:0] last_z;

  assign out_free = !out_valid || out_ready;
  assign in_ready = rst_n && (state != FLUSH1) && (state != FLUSH2) && out_free;
  assign acc      = in_valid && in_ready;
  // The subtract flag of a new frame applies to its own digit 0 already.
  assign eff_sub  = (acc && in_first) ? in_sub : sub_q;

  // Per-lane two-level carry-save addition; lanes never share carries.
  always_comb begin
    yp_e   = '0;
    yn_e   = '0;
    c_new  = '0;
    s1_new = '0;
    cc     = '0;
    s2     = '0;
    emit_z = '0;
    last_z = '0;
    cin    = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      yp_e[k] = eff_sub ? in_y[2*k]   : in_y[2*k+1];
      yn_e[k] = eff_sub ? in_y[2*k+1] : in_y[2*k];
      {c_new[k], s1_new[k]} = {1'b0, in_x[2*k+1]} + {1'b0, ~in_x[2*k]} + {1'b0, yp_e[k]};
      cin = (state == FLUSH1) ? 1'b0 : c_new[k];
      {cc[k], s2[k]} = {1'b0, s1_prev[k]} + {1'b0, ~yn_prev[k]} + {1'b0, cin};
      emit_z[2*k+1] = pend_p[k];
      emit_z[2*k]   = ~cc[k];
      last_z[2*k+1] = pend_p[k];
      last_z[2*k]   = 1'b0;
    end
  end

  // Sequencing FSM with registered output stage and per-lane state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sub_q       <= 1'b0;
      single      <= 1'b0;
      s1_prev     <= '0;
      yn_prev     <= '0;
      pend_p      <= '0;
      out_valid   <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      out_z       <= '0;
      restart_err <= 1'b0;
    end else begin
      restart_err <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Digits arriving without in_first are accepted and dropped.
          if (acc && in_first) begin
            sub_q   <= in_sub;
            single  <= in_last;
            pend_p  <= c_new;
            s1_prev <= s1_new;
            yn_prev <= yn_e;
            state   <= in_last ? FLUSH1 : FILL;
          end
        end
        FILL, STREAM: begin
          if (acc) begin
            if (in_first) begin
              // Abandon the running frame; this digit becomes a new digit 0.
              restart_err <= 1'b1;
              sub_q       <= in_sub;
              single      <= in_last;
              pend_p      <= c_new;
              s1_prev     <= s1_new;
              yn_prev     <= yn_e;
              state       <= in_last ? FLUSH1 : FILL;
            end else begin
              out_valid <= 1'b1;
              out_first <= (state == FILL);
              out_last  <= 1'b0;
              out_z     <= emit_z;
              pend_p    <= s2;
              s1_prev   <= s1_new;
              yn_prev   <= yn_e;
              state     <= in_last ? FLUSH1 : STREAM;
            end
          end
        end
        FLUSH1: begin
          if (out_free) begin
            out_valid <= 1'b1;
            out_first <= single;
            out_last  <= 1'b0;
            out_z     <= emit_z;
            pend_p    <= s2;
            state     <= FLUSH2;
          end
        end
        FLUSH2: begin
          if (out_free) begin
            out_valid <= 1'b1;
            out_first <= 1'b0;
            out_last  <= 1'b1;
            out_z     <= last_z;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
